eth_stream_arbiter: RTL and testbench

//   Downstream consumer of the per-channel AXI tap submodules (AW/W/AR/R/B) of the Ethernet helper.

---
 rtl/eth_stream_arbiter.sv | 150 +++++++++++++++
 tb/tb_eth_stream_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_stream_arbiter.sv
// Round-robin packet arbiter merging the AXI tap sources into one AXI-Stream via a 2-entry FWFT FIFO.
// Optional ETH_ARB_STATS_EN adds a saturating pkt_count output.
//
// state | meaning
// IDLE  | no grant; pick the next requesting source round-robin from rr_ptr
// GRANT | source gnt owns the output until it delivers a beat with in_progress=0
module eth_stream_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRC    = 5,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [SRC_W-1:0]              m_axis_tid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
`ifdef ETH_ARB_STATS_EN
  ,
  output logic [31:0]                   pkt_count
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] gnt, gnt_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_nxt;
  logic [SRC_W-1:0] rr_pick;
  logic [SRC_W:0]   idx_sum;

  logic                  push, pop, push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  fifo_full;
  logic [1:0]            count, count_nxt;
  logic                  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [SRC_W-1:0]      fifo_id   [2];
  logic                  fifo_last [2];

  // Lowest offset from rr_ptr wins, so scan offsets from high to low.
  always_comb begin
    rr_pick = rr_ptr;
    idx_sum = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx_sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (idx_sum >= (SRC_W+1)'(NUM_SRC)) idx_sum = idx_sum - (SRC_W+1)'(NUM_SRC);
      if (src_valid[idx_sum[SRC_W-1:0]]) rr_pick = idx_sum[SRC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  assign push_last = ~src_in_progress[gnt];
  assign push_data = src_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];

  // src_ready depends only on registered state, never on m_axis_tready.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_ptr;
    src_ready = '0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (|src_valid) begin
          gnt_nxt   = rr_pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        src_ready[gnt] = ~fifo_full;
        push           = src_valid[gnt] & ~fifo_full;
        if (push && push_last) begin
          state_nxt = IDLE;
          rr_nxt    = (gnt == SRC_W'(NUM_SRC - 1)) ? '0 : gnt + SRC_W'(1);
        end
      end
    endcase
  end

  assign fifo_full     = (count == 2'd2);
  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tid    = fifo_id[rd_ptr];
  assign m_axis_tlast  = fifo_last[rd_ptr];
  assign pop           = m_axis_tvalid & m_axis_tready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Entries are cleared on reset so the outputs read back as zero immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        fifo_data[e] <= '0;
        fifo_id[e]   <= '0;
        fifo_last[e] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_id[wr_ptr]   <= gnt;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_nxt;
    end
  end

`ifdef ETH_ARB_STATS_EN
  logic [31:0] pkt_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_count_q <= '0;
    end else if (pop && m_axis_tlast && (pkt_count_q != 32'hFFFF_FFFF)) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Scoreboard bench for eth_stream_arbiter: directed packets, expected beats queued in predicted output order.
module tb_eth_stream_arbiter;
  localparam int DW = 128;
  localparam int NS = 5;
  localparam int SW = 3;
  localparam int QD = 64;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_in_progress;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_ready;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tid;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
`ifdef ETH_ARB_STATS_EN
  logic [31:0]       pkt_count;
`endif

  eth_stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .src_valid       (src_valid),
    .src_in_progress (src_in_progress),
    .src_data        (src_data),
    .src_ready       (src_ready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tid      (m_axis_tid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready)
`ifdef ETH_ARB_STATS_EN
    ,
    .pkt_count       (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] id;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] bq_d  [NS][QD];
  logic          bq_ip [NS][QD];
  int            bq_wr [NS];
  int            bq_rd [NS];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic add_beat(input int s, input logic [DW-1:0] d, input logic ip);
    bq_d[s][bq_wr[s] % QD]  = d;
    bq_ip[s][bq_wr[s] % QD] = ip;
    bq_wr[s]++;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input int id, input logic last);
    beat_t b;
    b.d = d;
    b.id = SW'(id);
    b.last = last;
    exp_q.push_back(b);
  endtask

  function automatic bit pending();
    for (int i = 0; i < NS; i++) if (bq_rd[i] != bq_wr[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || pending()) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_accept(input string name, input int s, input int k, input int budget);
    int n = 0;
    while (bq_rd[s] < k && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_accept: src%0d accepted %0d beats, required %0d", name, s, bq_rd[s], k);
    end
  endtask

  // Source driver: presents queue heads, retires a beat after a seen handshake.
  initial begin
    logic [NS-1:0] acc;
    src_valid = '0;
    src_in_progress = '0;
    src_data = '0;
    for (int i = 0; i < NS; i++) begin
      bq_wr[i] = 0;
      bq_rd[i] = 0;
    end
    forever begin
      @(negedge clk);
      acc = resetn ? (src_valid & src_ready) : '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) bq_rd[i]++;
        if (bq_rd[i] < bq_wr[i]) begin
          src_valid[i] = 1'b1;
          src_in_progress[i] = bq_ip[i][bq_rd[i] % QD];
          src_data[i*DW +: DW] = bq_d[i][bq_rd[i] % QD];
        end else begin
          src_valid[i] = 1'b0;
          src_in_progress[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard compare on handshake, plus hold-stable check under backpressure.
  initial begin
    beat_t cur, pb, e;
    logic  pv, pr;
    pv = 1'b0;
    pr = 1'b0;
    pb = '0;
    forever begin
      @(negedge clk);
      cur.d = m_axis_tdata;
      cur.id = m_axis_tid;
      cur.last = m_axis_tlast;
      if (resetn) begin
        if (pv && !pr) begin
          n_cmp++;
          if (!m_axis_tvalid || cur !== pb) begin
            n_bad++;
            $display("FAIL axis_stable: got valid %0b tid %0d data %0h, required valid 1 tid %0d data %0h",
                     m_axis_tvalid, cur.id, cur.d, pb.id, pb.d);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: got tid %0d data %0h last %0b, required no beat", cur.id, cur.d, cur.last);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_bad++;
              $display("FAIL out_beat: got tid %0d data %0h last %0b, required tid %0d data %0h last %0b",
                       cur.id, cur.d, cur.last, e.id, e.d, e.last);
            end
          end
        end
        pv = m_axis_tvalid;
        pr = m_axis_tready;
        pb = cur;
      end else begin
        pv = 1'b0;
      end
    end
  end

  initial begin
    int b0;
    m_axis_tready = 1'b1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tid", m_axis_tid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_src_ready", src_ready, 0);
    resetn = 1'b1;
    @(posedge clk);
    #2;

    // T2: round robin over sources 0,1,3 starting from rr_ptr=0
    for (int r = 0; r < 2; r++) begin
      add_beat(0, 128'h2000 + DW'(r*16 + 0), 1'b0);
      add_beat(1, 128'h2000 + DW'(r*16 + 1), 1'b0);
      add_beat(3, 128'h2000 + DW'(r*16 + 3), 1'b0);
      expect_beat(128'h2000 + DW'(r*16 + 0), 0, 1'b1);
      expect_beat(128'h2000 + DW'(r*16 + 1), 1, 1'b1);
      expect_beat(128'h2000 + DW'(r*16 + 3), 3, 1'b1);
    end
    wait_idle("t2", 100);

    // T1: single beat, grant and latency timing (rr_ptr now 4)
    add_beat(2, 128'hA5, 1'b0);
    expect_beat(128'hA5, 2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t1_ready_idle", src_ready, 0);
    @(negedge clk);
    check("t1_ready_grant", src_ready, 5'b00100);
    check("t1_tvalid_before", m_axis_tvalid, 0);
    @(negedge clk);
    check("t1_tvalid_after", m_axis_tvalid, 1);
    wait_idle("t1", 50);

    // T3: 4-beat src0 packet, src1 joins during beat 2 but must wait
    b0 = bq_wr[0];
    add_beat(0, 128'h3000, 1'b1);
    add_beat(0, 128'h3001, 1'b1);
    add_beat(0, 128'h3002, 1'b1);
    add_beat(0, 128'h3003, 1'b0);
    expect_beat(128'h3000, 0, 1'b0);
    expect_beat(128'h3001, 0, 1'b0);
    expect_beat(128'h3002, 0, 1'b0);
    expect_beat(128'h3003, 0, 1'b1);
    expect_beat(128'h3100, 1, 1'b1);
    wait_accept("t3", 0, b0 + 1, 50);
    add_beat(1, 128'h3100, 1'b0);
    wait_idle("t3", 100);

    // T5: reset in the middle of a backpressured src2 packet (rr_ptr now 2)
    m_axis_tready = 1'b0;
    b0 = bq_wr[2];
    add_beat(2, 128'h5000, 1'b1);
    add_beat(2, 128'h5001, 1'b1);
    add_beat(2, 128'h5002, 1'b1);
    add_beat(2, 128'h5003, 1'b0);
    wait_accept("t5", 2, b0 + 2, 50);
    @(posedge clk);
    #2;
    check("t5_pre_tvalid", m_axis_tvalid, 1);
    check("t5_pre_rr_ptr", dut.rr_ptr, 2);
    resetn = 1'b0;
    bq_rd[2] = bq_wr[2];
    #1;
    check("t5_rst_tvalid", m_axis_tvalid, 0);
    check("t5_rst_src_ready", src_ready, 0);
    check("t5_rst_rr_ptr", dut.rr_ptr, 0);
    check("t5_rst_tdata", m_axis_tdata, 0);
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    m_axis_tready = 1'b1;
    add_beat(3, 128'h5300, 1'b1);
    add_beat(3, 128'h5301, 1'b0);
    expect_beat(128'h5300, 3, 1'b0);
    expect_beat(128'h5301, 3, 1'b1);
    wait_idle("t5", 100);

    // T4: 6-beat src4 packet with tready low for 5 cycles
    m_axis_tready = 1'b0;
    b0 = bq_wr[4];
    for (int k = 0; k < 6; k++) begin
      add_beat(4, 128'h4000 + DW'(k), (k != 5));
      expect_beat(128'h4000 + DW'(k), 4, (k == 5));
    end
    repeat (5) @(posedge clk);
    #2;
    check("t4_accepted", DW'(bq_rd[4] - b0), 2);
    check("t4_src_ready", src_ready, 0);
    check("t4_tvalid", m_axis_tvalid, 1);
    check("t4_head", m_axis_tdata, 128'h4000);
    m_axis_tready = 1'b1;
    wait_idle("t4", 100);

`ifdef ETH_ARB_STATS_EN
    // T6: packet counter and saturation
    resetn = 1'b0;
    @(posedge clk);
    #2;
    resetn = 1'b1;
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k <= p % 3; k++) begin
        add_beat(p % 5, 128'h6000 + DW'(p*16 + k), (k != p % 3));
        expect_beat(128'h6000 + DW'(p*16 + k), p % 5, (k == p % 3));
      end
    end
    wait_idle("t6", 300);
    check("t6_pkt_count", pkt_count, 10);
    force dut.pkt_count_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #2;
    release dut.pkt_count_q;
    for (int p = 0; p < 3; p++) begin
      add_beat(1, 128'h6F00 + DW'(p), 1'b0);
      expect_beat(128'h6F00 + DW'(p), 1, 1'b1);
    end
    wait_idle("t6_sat", 100);
    check("t6_pkt_count_sat", pkt_count, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    check("end_tvalid", m_axis_tvalid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
